// File: rtl/pattern_search_ctrl.sv
// Sequencer for pattern_search: loads the golden pattern, arms the searcher via search_rst, collects info frames.
// Optional macro PSC_AUTO_REARM_EN: re-arm the searcher automatically after every frame.
module pattern_search_ctrl #(
  parameter int N_BITS         = 8,
  parameter int PATTERN_SIZE   = 10,
  parameter int INFO_SIZE      = 2,
  parameter int CLEAR_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load_start,
  input  logic [N_BITS-1:0]               cfg_byte,
  input  logic                            cfg_valid,
  input  logic                            arm,
  input  logic                            abort,
  input  logic [N_BITS-1:0]               info_data,
  input  logic                            info_valid,
  output logic [N_BITS-1:0]               golden_word,
  output logic [$clog2(PATTERN_SIZE)-1:0] golden_word_index,
  output logic                            golden_word_valid,
  output logic                            search_rst,
  output logic [INFO_SIZE*N_BITS-1:0]     frame_data,
  output logic                            frame_valid,
  output logic                            timeout,
  output logic                            busy,
  output logic                            pattern_loaded
);
  localparam int IW = $clog2(PATTERN_SIZE);
  localparam int FW = INFO_SIZE * N_BITS;
  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  localparam int BW = $clog2(INFO_SIZE + 1);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [IW-1:0] IDX_LAST  = IW'(PATTERN_SIZE - 1);
  localparam logic [CW-1:0] CLR_LAST  = CW'(CLEAR_CYCLES - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(INFO_SIZE - 1);
  localparam logic [TW-1:0] TO_LIM    = TW'(TIMEOUT_CYCLES);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] CLEAR   = 3'd2;
  localparam logic [2:0] ARMED   = 3'd3;
  localparam logic [2:0] COLLECT = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     clr_cnt_q, clr_cnt_d;
  logic [BW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic [N_BITS-1:0] gw_q, gw_d;
  logic [IW-1:0]     gw_idx_q, gw_idx_d;
  logic              gw_vld_q, gw_vld_d;
  logic              srch_rst_q, srch_rst_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic              frame_vld_q, frame_vld_d;
  logic              timeout_q, timeout_d;
  logic              busy_q, busy_d;
  logic              loaded_q, loaded_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    clr_cnt_d   = clr_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    to_cnt_d    = to_cnt_q;
    gw_d        = gw_q;
    gw_idx_d    = gw_idx_q;
    gw_vld_d    = 1'b0;
    srch_rst_d  = srch_rst_q;
    frame_d     = frame_q;
    frame_vld_d = 1'b0;
    timeout_d   = 1'b0;
    loaded_d    = loaded_q;

    if (abort) begin
      state_d    = IDLE;
      idx_d      = '0;
      clr_cnt_d  = '0;
      byte_cnt_d = '0;
      to_cnt_d   = '0;
      srch_rst_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_start) begin
            state_d  = LOAD;
            idx_d    = '0;
            loaded_d = 1'b0;
          end else if (arm) begin
            state_d    = CLEAR;
            srch_rst_d = 1'b1;
            clr_cnt_d  = '0;
            byte_cnt_d = '0;
            to_cnt_d   = '0;
          end
        end
        LOAD: begin
          if (cfg_valid) begin
            gw_d     = cfg_byte;
            gw_idx_d = idx_q;
            gw_vld_d = 1'b1;
            if (idx_q == IDX_LAST) begin
              state_d  = IDLE;
              loaded_d = 1'b1;
              idx_d    = '0;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
        CLEAR: begin
          if (clr_cnt_q == CLR_LAST) begin
            state_d    = ARMED;
            srch_rst_d = 1'b0;
            clr_cnt_d  = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + CW'(1);
          end
        end
        ARMED, COLLECT: begin
          if (info_valid) begin
            frame_d = (frame_q << N_BITS) | FW'(info_data);
            if (byte_cnt_q == BYTE_LAST) begin
              state_d     = DONE;
              frame_vld_d = 1'b1;
              byte_cnt_d  = '0;
            end else begin
              state_d    = COLLECT;
              byte_cnt_d = byte_cnt_q + BW'(1);
            end
          end
          // A byte landing on the limit cycle is kept; completing the frame beats the timeout.
          if (TIMEOUT_CYCLES > 0 && state_d != DONE) begin
            to_cnt_d = to_cnt_q + TW'(1);
            if (to_cnt_d == TO_LIM) begin
              state_d    = IDLE;
              timeout_d  = 1'b1;
              to_cnt_d   = '0;
              byte_cnt_d = '0;
            end
          end
        end
        DONE: begin
`ifdef PSC_AUTO_REARM_EN
          state_d    = CLEAR;
          srch_rst_d = 1'b1;
          clr_cnt_d  = '0;
          byte_cnt_d = '0;
          to_cnt_d   = '0;
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      clr_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      to_cnt_q    <= '0;
      gw_q        <= '0;
      gw_idx_q    <= '0;
      gw_vld_q    <= 1'b0;
      srch_rst_q  <= 1'b0;
      frame_q     <= '0;
      frame_vld_q <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      loaded_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      clr_cnt_q   <= clr_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      to_cnt_q    <= to_cnt_d;
      gw_q        <= gw_d;
      gw_idx_q    <= gw_idx_d;
      gw_vld_q    <= gw_vld_d;
      srch_rst_q  <= srch_rst_d;
      frame_q     <= frame_d;
      frame_vld_q <= frame_vld_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      loaded_q    <= loaded_d;
    end
  end

  assign golden_word       = gw_q;
  assign golden_word_index = gw_idx_q;
  assign golden_word_valid = gw_vld_q;
  assign search_rst        = srch_rst_q;
  assign frame_data        = frame_q;
  assign frame_valid       = frame_vld_q;
  assign timeout           = timeout_q;
  assign busy              = busy_q;
  assign pattern_loaded    = loaded_q;

endmodule

// File: tb/tb_pattern_search_ctrl.sv
// Directed bench for pattern_search_ctrl: two instances (timeout 20 and 10) share one stimulus stream.
module tb_pattern_search_ctrl;
`ifdef PSC_AUTO_REARM_EN
  localparam logic REARM = 1'b1;
`else
  localparam logic REARM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, load_start, cfg_valid, arm, abort, info_valid;
  logic [7:0] cfg_byte, info_data;

  logic [7:0]  gw_a, gw_b;
  logic [1:0]  gwi_a, gwi_b;
  logic        gwv_a, gwv_b, srst_a, srst_b, fv_a, fv_b, to_a, to_b;
  logic        busy_a, busy_b, pl_a, pl_b;
  logic [15:0] fd_a, fd_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pattern_search_ctrl #(.N_BITS(8), .PATTERN_SIZE(4), .INFO_SIZE(2), .CLEAR_CYCLES(2),
                        .TIMEOUT_CYCLES(20)) u_dut_a (
    .clk(clk), .rst(rst), .load_start(load_start), .cfg_byte(cfg_byte), .cfg_valid(cfg_valid),
    .arm(arm), .abort(abort), .info_data(info_data), .info_valid(info_valid),
    .golden_word(gw_a), .golden_word_index(gwi_a), .golden_word_valid(gwv_a),
    .search_rst(srst_a), .frame_data(fd_a), .frame_valid(fv_a), .timeout(to_a),
    .busy(busy_a), .pattern_loaded(pl_a));

  pattern_search_ctrl #(.N_BITS(8), .PATTERN_SIZE(4), .INFO_SIZE(2), .CLEAR_CYCLES(2),
                        .TIMEOUT_CYCLES(10)) u_dut_b (
    .clk(clk), .rst(rst), .load_start(load_start), .cfg_byte(cfg_byte), .cfg_valid(cfg_valid),
    .arm(arm), .abort(abort), .info_data(info_data), .info_valid(info_valid),
    .golden_word(gw_b), .golden_word_index(gwi_b), .golden_word_valid(gwv_b),
    .search_rst(srst_b), .frame_data(fd_b), .frame_valid(fv_b), .timeout(to_b),
    .busy(busy_b), .pattern_loaded(pl_b));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs set before tick are seen at the next edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic arm_to_armed();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check_eq("arm_srst_c1", 32'(srst_a), 32'd1);
    tick();
    check_eq("arm_srst_c2", 32'(srst_a), 32'd1);
    tick();
    check_eq("arm_srst_off", 32'(srst_a), 32'd0);
    check_eq("arm_busy", 32'(busy_a), 32'd1);
  endtask

  initial begin
    logic [7:0] pat [4];
    int to_first_a, to_first_b, to_cnt_a, fv_seen;
    pat[0] = 8'hAA; pat[1] = 8'h55; pat[2] = 8'h0F; pat[3] = 8'hF0;
    rst = 1'b1; load_start = 1'b0; cfg_valid = 1'b0; arm = 1'b0; abort = 1'b0;
    info_valid = 1'b0; cfg_byte = 8'h00; info_data = 8'h00;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_loaded", 32'(pl_a), 32'd0);
    check_eq("rst_srst", 32'(srst_a), 32'd0);
    check_eq("rst_frame", 32'(fd_a), 32'd0);
    check_eq("rst_gwv", 32'(gwv_a), 32'd0);

    // Pattern load with idle gaps between bytes
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check_eq("load_busy", 32'(busy_a), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("load_gap_gwv", 32'(gwv_a), 32'd0);
      cfg_valid = 1'b1; cfg_byte = pat[i];
      tick();
      cfg_valid = 1'b0;
      check_eq("load_gwv", 32'(gwv_a), 32'd1);
      check_eq("load_gw", 32'(gw_a), 32'(pat[i]));
      check_eq("load_idx", 32'(gwi_a), 32'(i));
      check_eq("load_loaded", 32'(pl_a), (i == 3) ? 32'd1 : 32'd0);
    end
    check_eq("load_end_busy", 32'(busy_a), 32'd0);
    tick();
    check_eq("load_hold_gwv", 32'(gwv_a), 32'd0);
    check_eq("load_hold_gw", 32'(gw_a), 32'hF0);
    check_eq("load_hold_idx", 32'(gwi_a), 32'd3);

    // Arm and collect one frame
    arm_to_armed();
    info_valid = 1'b1; info_data = 8'h12;
    tick();
    info_data = 8'h34;
    check_eq("col_fv_early", 32'(fv_a), 32'd0);
    tick();
    info_valid = 1'b0;
    check_eq("col_fv", 32'(fv_a), 32'd1);
    check_eq("col_frame", 32'(fd_a), 32'h1234);
    check_eq("col_frame_b", 32'(fd_b), 32'h1234);
    tick();
    check_eq("col_fv_pulse", 32'(fv_a), 32'd0);
    check_eq("col_busy_after", 32'(busy_a), 32'(REARM));
    check_eq("col_frame_hold", 32'(fd_a), 32'h1234);
    do_abort();

    // Timeout: one byte then silence; A times out at ARMED+20, B at ARMED+10
    arm_to_armed();
    info_valid = 1'b1; info_data = 8'h12;
    tick();
    info_valid = 1'b0;
    to_first_a = -1; to_first_b = -1; to_cnt_a = 0; fv_seen = 0;
    for (int n = 2; n <= 30; n++) begin
      tick();
      if (to_a) begin
        to_cnt_a++;
        if (to_first_a < 0) to_first_a = n;
      end
      if (to_b && to_first_b < 0) to_first_b = n;
      if (fv_a || fv_b) fv_seen++;
    end
    check_eq("to_cycle_a", 32'(to_first_a), 32'd20);
    check_eq("to_cycle_b", 32'(to_first_b), 32'd10);
    check_eq("to_pulse_width", 32'(to_cnt_a), 32'd1);
    check_eq("to_no_frame", 32'(fv_seen), 32'd0);
    check_eq("to_busy", 32'(busy_a), 32'd0);
    check_eq("to_frame_hold", 32'(fd_a), 32'h3412);

    // Abort in the middle of a load
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check_eq("ab_loaded_clr", 32'(pl_a), 32'd0);
    cfg_valid = 1'b1; cfg_byte = 8'h11;
    tick();
    cfg_byte = 8'h22;
    tick();
    cfg_valid = 1'b0;
    do_abort();
    check_eq("ab_busy", 32'(busy_a), 32'd0);
    check_eq("ab_loaded", 32'(pl_a), 32'd0);
    cfg_valid = 1'b1; cfg_byte = 8'h77;
    tick();
    cfg_valid = 1'b0;
    check_eq("ab_cfg_ignored", 32'(gwv_a), 32'd0);
    check_eq("ab_gw_hold", 32'(gw_a), 32'h22);
    tick();
    check_eq("ab_cfg_ignored2", 32'(gwv_a), 32'd0);

    // load_start and arm together: load wins
    load_start = 1'b1; arm = 1'b1;
    tick();
    load_start = 1'b0; arm = 1'b0;
    check_eq("coll_busy", 32'(busy_a), 32'd1);
    check_eq("coll_srst", 32'(srst_a), 32'd0);
    tick();
    check_eq("coll_srst2", 32'(srst_a), 32'd0);
    do_abort();

    // Info byte while idle is ignored
    info_valid = 1'b1; info_data = 8'h99;
    tick();
    info_valid = 1'b0;
    check_eq("idle_info_ign", 32'(fd_a), 32'h3412);

    // Second byte lands exactly on B's timeout limit
    arm_to_armed();
    info_valid = 1'b1; info_data = 8'h56;
    tick();
    info_valid = 1'b0;
    for (int n = 2; n <= 9; n++) tick();
    check_eq("lim_to_pre", 32'(to_b), 32'd0);
    info_valid = 1'b1; info_data = 8'h78;
    tick();
    info_valid = 1'b0;
    check_eq("lim_fv_b", 32'(fv_b), 32'd1);
    check_eq("lim_to_b", 32'(to_b), 32'd0);
    check_eq("lim_frame_b", 32'(fd_b), 32'h5678);
    check_eq("lim_fv_a", 32'(fv_a), 32'd1);
    tick();
    check_eq("lim_to_b_after", 32'(to_b), 32'd0);
    check_eq("lim_busy_b", 32'(busy_b), 32'(REARM));
    do_abort();

`ifdef PSC_AUTO_REARM_EN
    // Auto re-arm: two frames from a single arm
    arm_to_armed();
    info_valid = 1'b1; info_data = 8'h12;
    tick();
    info_data = 8'h34;
    tick();
    info_valid = 1'b0;
    check_eq("ra_fv1", 32'(fv_a), 32'd1);
    check_eq("ra_frame1", 32'(fd_a), 32'h1234);
    tick();
    check_eq("ra_srst1a", 32'(srst_a), 32'd1);
    check_eq("ra_busy1", 32'(busy_a), 32'd1);
    tick();
    check_eq("ra_srst1b", 32'(srst_a), 32'd1);
    tick();
    check_eq("ra_srst1c", 32'(srst_a), 32'd0);
    info_valid = 1'b1; info_data = 8'hAB;
    tick();
    info_data = 8'hCD;
    tick();
    info_valid = 1'b0;
    check_eq("ra_fv2", 32'(fv_a), 32'd1);
    check_eq("ra_frame2", 32'(fd_a), 32'hABCD);
    tick();
    check_eq("ra_srst2a", 32'(srst_a), 32'd1);
    tick();
    check_eq("ra_srst2b", 32'(srst_a), 32'd1);
    tick();
    check_eq("ra_srst2c", 32'(srst_a), 32'd0);
    check_eq("ra_busy2", 32'(busy_a), 32'd1);
    do_abort();
    check_eq("ra_busy_abort", 32'(busy_a), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
